// File: rtl/xotr_seq_pkg.sv
// rtl/xotr_seq_pkg.sv - shared types and constants for the XOTR step sequencer
package xotr_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        MEM  = 2'd2
    } xotr_state_t;

    localparam logic [7:0] ED_PREFIX = 8'hED;
    localparam int         XPT_W     = 5;

    localparam logic [1:0] IM_0 = 2'd0;
    localparam logic [1:0] IM_1 = 2'd1;
    localparam logic [1:0] IM_2 = 2'd2;

endpackage

// File: rtl/xotr_mem_port.sv
// rtl/xotr_mem_port.sv - bus request hold logic; optional timeout under XOTR_MEM_TIMEOUT_EN
module xotr_mem_port
`ifdef XOTR_MEM_TIMEOUT_EN
#(
    parameter int MEM_TIMEOUT = 16
)
`endif
(
    input  logic       clock,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_we,
    input  logic [2:0] i_sel,
    input  logic       i_ack,
    output logic       o_req,
    output logic       o_we,
    output logic [2:0] o_sel,
    output logic       o_done,
    output logic       o_timeout
);

    logic       r_req;
    logic       r_we;
    logic [2:0] r_sel;
    logic       w_done;
    logic       w_timeout;

    // r_req is high exactly while the sequencer sits in MEM, so ack is qualified by it
    assign w_done = r_req & i_ack;

`ifdef XOTR_MEM_TIMEOUT_EN
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset || i_start) begin
            r_cnt <= '0;
        end else if (r_req) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_timeout = r_req & ~i_ack & (r_cnt == CW'(MEM_TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_req <= 1'b0;
            r_we  <= 1'b0;
            r_sel <= 3'd0;
        end else if (i_start) begin
            r_req <= 1'b1;
            r_we  <= i_we;
            r_sel <= i_sel;
        end else if (w_done || w_timeout) begin
            r_req <= 1'b0;
            r_we  <= 1'b0;
            r_sel <= 3'd0;
        end
    end

    assign o_req     = r_req;
    assign o_we      = r_we;
    assign o_sel     = r_sel;
    assign o_done    = w_done;
    assign o_timeout = w_timeout;

endmodule

// File: rtl/xotr_step_sequencer.sv
// rtl/xotr_step_sequencer.sv - XOTR opcode step sequencer; optional mem timeout under XOTR_MEM_TIMEOUT_EN
module xotr_step_sequencer
    import xotr_seq_pkg::*;
#(
    parameter int STEP_LIMIT = 31
`ifdef XOTR_MEM_TIMEOUT_EN
    , parameter int MEM_TIMEOUT = 16
`endif
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             fetch_valid,
    input  logic [7:0]       fetch_byte,
    output logic             fetch_ready,
    output logic             dec_enable,
    output logic [XPT_W-1:0] XPT,
    output logic [XPT_W-1:0] notXPT,
    output logic [7:0]       Source,
    output logic [7:0]       notSource,
    input  logic             PR_Reset_XPT,
    input  logic             P2_Set_CM1,
    input  logic             P2_Reset_XOTR,
    input  logic             Pa_Ophd,
    input  logic             PC_R0,
    input  logic             PC_R1,
    input  logic             PC_R2,
    input  logic             PC_W0,
    input  logic             PC_W1,
    input  logic             PC_W2,
    input  logic             P2_IM0,
    input  logic             P2_IM1,
    input  logic             P2_IM2,
    output logic             mem_req,
    output logic             mem_we,
    output logic [2:0]       mem_sel,
    input  logic             mem_ack,
    output logic             cm1_pulse,
    output logic             ophd,
    output logic             xotr_active,
    output logic [1:0]       im_mode,
    output logic             fault
);

    localparam logic [XPT_W-1:0] LIMIT = XPT_W'(STEP_LIMIT);

    xotr_state_t      r_state;
    logic [XPT_W-1:0] r_xpt;
    logic [7:0]       r_source;
    logic             r_cm1;
    logic             r_ophd;
    logic             r_active;
    logic [1:0]       r_im;
    logic             r_fault;

    logic [2:0] w_rd;
    logic [2:0] w_wr;
    logic [2:0] w_im;
    logic       w_start;
    logic       w_start_we;
    logic       w_done;
    logic       w_timeout;

    assign w_rd = {PC_R2, PC_R1, PC_R0};
    assign w_wr = {PC_W2, PC_W1, PC_W0};
    assign w_im = {P2_IM2, P2_IM1, P2_IM0};

    // A bus cycle starts only when exactly one of the read/write codes is active
    assign w_start    = (r_state == STEP) && !PR_Reset_XPT &&
                        ((w_rd != 3'd0) != (w_wr != 3'd0));
    assign w_start_we = (w_rd == 3'd0);

    xotr_mem_port
`ifdef XOTR_MEM_TIMEOUT_EN
    #(.MEM_TIMEOUT(MEM_TIMEOUT))
`endif
    u_mem_port (
        .clock     (clock),
        .reset     (reset),
        .i_start   (w_start),
        .i_we      (w_start_we),
        .i_sel     (w_start_we ? w_wr : w_rd),
        .i_ack     (mem_ack),
        .o_req     (mem_req),
        .o_we      (mem_we),
        .o_sel     (mem_sel),
        .o_done    (w_done),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_xpt    <= '0;
            r_source <= 8'd0;
            r_cm1    <= 1'b0;
            r_ophd   <= 1'b0;
            r_active <= 1'b0;
            r_im     <= IM_0;
            r_fault  <= 1'b0;
        end else begin
            r_cm1  <= 1'b0;
            r_ophd <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (fetch_valid) begin
                        if (r_active) begin
                            r_source <= fetch_byte;
                            r_xpt    <= '0;
                            r_state  <= STEP;
                        end else if (fetch_byte == ED_PREFIX) begin
                            r_active <= 1'b1;
                        end
                    end
                end
                STEP: begin
                    if (PR_Reset_XPT) begin
                        r_xpt   <= '0;
                        r_state <= IDLE;
                        r_cm1   <= P2_Set_CM1;
                        r_ophd  <= Pa_Ophd;
                        if (P2_Reset_XOTR) begin
                            r_active <= 1'b0;
                        end
                    end else if (w_rd != 3'd0 && w_wr != 3'd0) begin
                        r_fault  <= 1'b1;
                        r_active <= 1'b0;
                        r_state  <= IDLE;
                    end else if (w_rd != 3'd0 || w_wr != 3'd0) begin
                        r_state <= MEM;
                    end else if (r_xpt == LIMIT) begin
                        r_fault  <= 1'b1;
                        r_active <= 1'b0;
                        r_xpt    <= '0;
                        r_state  <= IDLE;
                    end else begin
                        r_xpt <= r_xpt + 1'b1;
                    end

                    // Interrupt-mode strobes are decoded alongside the step priority chain
                    case (w_im)
                        3'b000: ;
                        3'b001: r_im <= IM_0;
                        3'b010: r_im <= IM_1;
                        3'b100: r_im <= IM_2;
                        default: r_fault <= 1'b1;
                    endcase
                end
                MEM: begin
                    if (w_done) begin
                        r_xpt   <= r_xpt + 1'b1;
                        r_state <= STEP;
                    end else if (w_timeout) begin
                        r_fault  <= 1'b1;
                        r_active <= 1'b0;
                        r_xpt    <= '0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign fetch_ready = (r_state == IDLE);
    assign dec_enable  = (r_state == STEP);
    assign XPT         = r_xpt;
    assign notXPT      = ~r_xpt;
    assign Source      = r_source;
    assign notSource   = ~r_source;
    assign cm1_pulse   = r_cm1;
    assign ophd        = r_ophd;
    assign xotr_active = r_active;
    assign im_mode     = r_im;
    assign fault       = r_fault;

endmodule

// File: tb/tb_xotr_step_sequencer.sv
// tb/tb_xotr_step_sequencer.sv - directed self-checking bench for xotr_step_sequencer
module tb_xotr_step_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       fetch_valid;
    logic [7:0] fetch_byte;
    logic       fetch_ready;
    logic       dec_enable;
    logic [4:0] XPT;
    logic [4:0] notXPT;
    logic [7:0] Source;
    logic [7:0] notSource;
    logic       PR_Reset_XPT, P2_Set_CM1, P2_Reset_XOTR, Pa_Ophd;
    logic       PC_R0, PC_R1, PC_R2, PC_W0, PC_W1, PC_W2;
    logic       P2_IM0, P2_IM1, P2_IM2;
    logic       mem_req, mem_we;
    logic [2:0] mem_sel;
    logic       mem_ack;
    logic       cm1_pulse, ophd, xotr_active, fault;
    logic [1:0] im_mode;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    xotr_step_sequencer dut (
        .clock(clock), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_byte(fetch_byte), .fetch_ready(fetch_ready),
        .dec_enable(dec_enable), .XPT(XPT), .notXPT(notXPT),
        .Source(Source), .notSource(notSource),
        .PR_Reset_XPT(PR_Reset_XPT), .P2_Set_CM1(P2_Set_CM1),
        .P2_Reset_XOTR(P2_Reset_XOTR), .Pa_Ophd(Pa_Ophd),
        .PC_R0(PC_R0), .PC_R1(PC_R1), .PC_R2(PC_R2),
        .PC_W0(PC_W0), .PC_W1(PC_W1), .PC_W2(PC_W2),
        .P2_IM0(P2_IM0), .P2_IM1(P2_IM1), .P2_IM2(P2_IM2),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_ack(mem_ack),
        .cm1_pulse(cm1_pulse), .ophd(ophd), .xotr_active(xotr_active),
        .im_mode(im_mode), .fault(fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_dec();
        {PR_Reset_XPT, P2_Set_CM1, P2_Reset_XOTR, Pa_Ophd} = 4'b0;
        {PC_R0, PC_R1, PC_R2, PC_W0, PC_W1, PC_W2} = 6'b0;
        {P2_IM0, P2_IM1, P2_IM2} = 3'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic start_op(input logic [7:0] op);
        fetch_valid = 1'b1;
        fetch_byte  = 8'hED;
        tick();
        fetch_byte  = op;
        tick();
        fetch_valid = 1'b0;
        fetch_byte  = 8'h00;
    endtask

    initial begin
        reset = 1'b1; fetch_valid = 1'b0; fetch_byte = 8'h00; mem_ack = 1'b0;
        clr_dec();
        tick();
        tick();

        // reset state
        chk("rst_xpt", {27'd0, XPT}, 32'h0);
        chk("rst_notxpt", {27'd0, notXPT}, 32'h1F);
        chk("rst_notsrc", {24'd0, notSource}, 32'hFF);
        chk("rst_flags", {28'd0, xotr_active, fault, mem_req, dec_enable}, 32'h0);
        chk("rst_im", {30'd0, im_mode}, 32'h0);
        chk("rst_ready", {31'd0, fetch_ready}, 32'h1);
        reset = 1'b0;

        // non-ED byte without prefix is ignored
        fetch_valid = 1'b1; fetch_byte = 8'h3E;
        tick();
        chk("nonED_ignored", {30'd0, xotr_active, fetch_ready}, 32'h1);

        // IM 1 instruction
        fetch_byte = 8'hED;
        tick();
        chk("ed_active", {30'd0, xotr_active, fetch_ready}, 32'h3);
        fetch_byte = 8'h56;
        tick();
        fetch_valid = 1'b0;
        chk("im1_latch", {16'd0, Source, notSource}, 32'h56A9);
        chk("im1_dec_en", {30'd0, dec_enable, fetch_ready}, 32'h2);
        tick();
        chk("im1_xpt1", {22'd0, XPT, notXPT}, {22'd0, 5'd1, 5'h1E});
        P2_IM1 = 1'b1;
        tick();
        clr_dec();
        chk("im1_mode", {27'd0, XPT, 2'd0, im_mode}, {27'd0, 5'd2, 2'd0, 2'd1});
        PR_Reset_XPT = 1'b1; P2_Set_CM1 = 1'b1; P2_Reset_XOTR = 1'b1;
        tick();
        clr_dec();
        chk("im1_end", {24'd0, XPT, cm1_pulse, xotr_active, fetch_ready}, {24'd0, 5'd0, 3'b101});
        tick();
        chk("im1_cm1_once", {30'd0, cm1_pulse, im_mode == 2'd1}, 32'h1);

        // RRD with a read then a write, ack delayed 3 cycles each
        start_op(8'h67);
        tick();
        tick();
        chk("rrd_xpt2", {27'd0, XPT}, 32'd2);
        PC_R0 = 1'b1;
        tick();
        clr_dec();
        chk("rrd_rd_req", {26'd0, mem_req, mem_we, mem_sel, dec_enable}, {26'd0, 6'b100010});
        tick();
        tick();
        chk("rrd_rd_hold", {22'd0, XPT, mem_req, mem_we, mem_sel}, {22'd0, 5'd2, 5'b10001});
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("rrd_rd_done", {25'd0, XPT, mem_req, dec_enable}, {25'd0, 5'd3, 2'b01});
        tick();
        tick();
        PC_W0 = 1'b1;
        tick();
        clr_dec();
        chk("rrd_wr_req", {22'd0, XPT, mem_req, mem_we, mem_sel}, {22'd0, 5'd5, 5'b11001});
        tick();
        tick();
        chk("rrd_wr_hold", {22'd0, XPT, mem_req, mem_we, mem_sel}, {22'd0, 5'd5, 5'b11001});
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("rrd_wr_done", {26'd0, XPT, mem_req}, {26'd0, 5'd6, 1'b0});
        PR_Reset_XPT = 1'b1; P2_Reset_XOTR = 1'b1; Pa_Ophd = 1'b1;
        tick();
        clr_dec();
        chk("rrd_end", {29'd0, ophd, xotr_active, fetch_ready}, 32'h5);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("ack_outside_mem", {29'd0, ophd, mem_req, fetch_ready}, 32'h1);

        // simultaneous read and write codes
        start_op(8'h00);
        tick();
        PC_R0 = 1'b1; PC_W0 = 1'b1;
        tick();
        clr_dec();
        chk("rw_fault", {28'd0, fault, fetch_ready, mem_req, xotr_active}, 32'hC);
        tick();
        chk("rw_no_req", {30'd0, mem_req, fault}, 32'h1);
        do_reset();
        chk("fault_cleared", {31'd0, fault}, 32'h0);

        // runaway step counter
        start_op(8'h11);
        for (int i = 0; i < 31; i++) tick();
        chk("run_xpt31", {26'd0, XPT, fault}, {26'd0, 5'd31, 1'b0});
        tick();
        chk("run_fault", {24'd0, XPT, fault, xotr_active, fetch_ready}, {24'd0, 5'd0, 3'b101});
        do_reset();

        // reset while a bus cycle is pending
        start_op(8'h42);
        PC_R1 = 1'b1;
        tick();
        clr_dec();
        chk("mid_req", {28'd0, mem_req, mem_sel}, 32'hA);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_bus", {27'd0, mem_req, mem_we, mem_sel}, 32'h0);
        chk("mid_rst_src", {8'd0, Source, notSource, 3'd0, XPT}, 32'h00FF00);
        chk("mid_rst_misc", {27'd0, cm1_pulse, ophd, xotr_active, dec_enable, fetch_ready}, 32'h1);

        // multiple IM strobes fault and leave im_mode unchanged
        start_op(8'h5E);
        P2_IM2 = 1'b1;
        tick();
        clr_dec();
        chk("im2_mode", {29'd0, fault, im_mode}, 32'h2);
        P2_IM0 = 1'b1; P2_IM1 = 1'b1;
        tick();
        clr_dec();
        chk("im_multi", {29'd0, fault, im_mode}, 32'h6);
        do_reset();

        // bus cycle with no acknowledge
        start_op(8'h33);
        PC_W2 = 1'b1;
        tick();
        clr_dec();
        chk("noack_req", {27'd0, mem_req, mem_we, mem_sel}, 32'h1C);
`ifdef XOTR_MEM_TIMEOUT_EN
        for (int i = 0; i < 15; i++) tick();
        chk("to_before", {30'd0, mem_req, fault}, 32'h2);
        tick();
        chk("to_fire", {28'd0, mem_req, fault, xotr_active, fetch_ready}, 32'h5);
`else
        for (int i = 0; i < 100; i++) tick();
        chk("noack_hold", {26'd0, mem_req, fault, mem_sel, dec_enable}, 32'h28);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xotr_step_sequencer.md
Name: xotr_step_sequencer

Overview:
- Drives the XOTR (ED-prefixed) opcode decoder tree.
- Latches the opcode byte, generates the XPT step counter and its complements, and services the decoder's memory-cycle requests with a bus handshake.
- Ends the instruction on PR_Reset_XPT, fires the CM1 pulse, clears XOTR mode and holds the interrupt-mode register.
- Sits between the fetch unit and the decoder tree.

Parameters:
STEP_LIMIT, 31, last legal XPT value (1..31) before a runaway fault.
MEM_TIMEOUT, 16, cycles allowed for mem_ack (used only with XOTR_MEM_TIMEOUT_EN).

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
fetch_valid  in  1  fetch unit offers fetch_byte
fetch_byte  in  8  fetched opcode byte
fetch_ready  out  1  sequencer accepts a byte this cycle
dec_enable  out  1  enable to decoder tree
XPT / notXPT  out  5 / 5  step count and exact complement
Source / notSource  out  8 / 8  latched opcode and exact complement
PR_Reset_XPT, P2_Set_CM1, P2_Reset_XOTR, Pa_Ophd  in  1 each  decoder end-of-instruction pulses
PC_R0, PC_R1, PC_R2  in  1 each  read request code {R2,R1,R0}
PC_W0, PC_W1, PC_W2  in  1 each  write request code {W2,W1,W0}
P2_IM0, P2_IM1, P2_IM2  in  1 each  set interrupt mode
mem_req  out  1  bus cycle request
mem_we  out  1  1=write
mem_sel  out  3  request code
mem_ack  in  1  bus cycle complete
cm1_pulse  out  1  one-cycle M1 restart to fetch unit
ophd  out  1  one-cycle opcode-handled strobe
xotr_active  out  1  ED prefix seen
im_mode  out  2  interrupt mode 0/1/2
fault  out  1  sticky error flag, cleared only by reset

Behaviour:
Reset values:
- State IDLE; XPT=0, notXPT=5'h1F, Source=0, notSource=8'hFF.
- xotr_active=0, im_mode=0, fault=0.
- mem_req=0, mem_we=0, mem_sel=0, cm1_pulse=0, ophd=0, dec_enable=0.
- Reset mid-operation drops mem_req on the same edge. No bus-cycle completion is implied.

State IDLE (fetch_ready=1, dec_enable=0):
- fetch_valid with byte 8'hED and xotr_active=0: set xotr_active, stay IDLE.
- fetch_valid with xotr_active=1: latch Source=fetch_byte, XPT=0, go STEP next cycle.
- fetch_valid with a non-ED byte and xotr_active=0: ignored; ownership stays with the main decoder.

State STEP (dec_enable=1, fetch_ready=0). Inputs are sampled every cycle; the priority order is:
1. PR_Reset_XPT: XPT=0, go IDLE. Pulse cm1_pulse for 1 cycle if P2_Set_CM1. Pulse ophd for 1 cycle if Pa_Ophd. Clear xotr_active if P2_Reset_XOTR.
2. Both a read code and a write code nonzero: set fault, clear xotr_active, go IDLE.
3. Read code nonzero: mem_req=1, mem_we=0, mem_sel=code, go MEM; XPT holds.
4. Write code nonzero: same as read with mem_we=1.
5. Otherwise XPT+1. XPT==STEP_LIMIT with no PR_Reset_XPT: set fault, clear xotr_active, XPT=0, go IDLE.

IM handling in STEP, independent of the priority list:
- Exactly one of P2_IM0/1/2 high: im_mode=0/1/2 on the next edge.
- More than one high: fault, im_mode unchanged.

State MEM (dec_enable=0, so decoder pulses are not resampled):
- mem_req, mem_we and mem_sel are held stable until mem_ack.
- On mem_ack: drop mem_req, XPT+1, return to STEP.
- mem_ack outside MEM is ignored.

Invariants and latencies:
- notXPT==~XPT and notSource==~Source on every cycle.
- Latency from fetch accept to first dec_enable is 1 cycle.

Optional Feature:
XOTR_MEM_TIMEOUT_EN:
- Defined: a counter runs in MEM. After MEM_TIMEOUT cycles without mem_ack, drop mem_req, set fault, clear xotr_active, go IDLE.
- Undefined: MEM waits indefinitely and no counter logic exists.

Decomposition:
- Package xotr_seq_pkg holds:
  - state enum {IDLE, STEP, MEM};
  - constant ED_PREFIX=8'hED;
  - IM encodings IM_0/IM_1/IM_2;
  - XPT width constant 5.
- One natural sub-module: xotr_mem_port, holding the mem_req/mem_we/mem_sel hold logic and the optional timeout counter.

Test Plan:
- ED then 8'h56 (IM 1): decoder stub pulses P2_IM1 at XPT=1, then PR_Reset_XPT+P2_Set_CM1+P2_Reset_XOTR at XPT=2. Expect im_mode=1, cm1_pulse for exactly 1 cycle, xotr_active=0, back in IDLE.
- ED then 8'h67 (RRD): stub asserts read code 3'b001 at XPT=2 and write code 3'b001 at XPT=5; mem_ack delayed 3 cycles. Expect XPT frozen during MEM, mem_we 0 then 1, with correct sequence.
- Stub asserts PC_R0 and PC_W0 together at XPT=1: fault=1, IDLE next cycle, mem_req never asserted.
- Stub never ends the instruction: fault at XPT=31, xotr_active=0, XPT=0.
- reset asserted while mem_req=1: next cycle all outputs equal their reset values; notSource=8'hFF.
- With XOTR_MEM_TIMEOUT_EN and MEM_TIMEOUT=16, no mem_ack: mem_req drops after 16 cycles and fault=1. Without the macro, mem_req is still high after 100 cycles.
